// File: rtl/boton_acondicionador.sv
// Input conditioning for the pet controller: 2-FF synchronisers, per-channel debounce FSMs,
// one-cycle press pulses, a debounced tilt level and a long-press detector on sleep.
module boton_acondicionador #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LONG_CYCLES     = 150000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sleep_r,
  input  logic btn_awake_r,
  input  logic btn_feed_r,
  input  logic btn_play_r,
  input  logic giro_r,
  output logic botonSleep,
  output logic botonAwake,
  output logic botonFeed,
  output logic botonPlay,
  output logic giro,
  output logic long_sleep
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [4:0]    IDLE_RAW  = ACTIVE_LOW ? 5'b11111 : 5'b00000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  logic [4:0] raw_s, p_s, pulse_s, lvl_s, in_hold_s, press_s;
  logic [4:0] sync1_q, sync2_q;
  logic [1:0] ready_q;

  assign raw_s = {giro_r, btn_play_r, btn_feed_r, btn_awake_r, btn_sleep_r};
  assign p_s   = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      ready_q <= 2'b00;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
      ready_q <= {ready_q[0], 1'b1};
    end
  end

  // A channel only arms once a real (post-reset) released level has crossed the synchroniser,
  // so a button still held through reset cannot produce a pulse.
  for (genvar g = 0; g < 5; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            pulse_q, lvl_q, press_d, lvl_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      armed_d = armed_q | (ready_q[1] & ~p_s[g]);
      case (state_q)
        RELEASED: begin
          if (p_s[g] && armed_q) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!p_s[g]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!p_s[g]) begin
            state_d = RELEASE_CHK;
            cnt_d   = '0;
          end
        end
        RELEASE_CHK: begin
          if (p_s[g]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
      lvl_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        armed_q <= 1'b0;
        pulse_q <= 1'b0;
        lvl_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        pulse_q <= press_d;
        lvl_q   <= lvl_d;
      end
    end

    assign pulse_s[g]   = pulse_q;
    assign lvl_s[g]     = lvl_q;
    assign press_s[g]   = press_d;
    assign in_hold_s[g] = (state_q == PRESSED) || (state_q == RELEASE_CHK);
  end

  logic [HW-1:0] hold_q, hold_d;
  logic          fired_q, fired_d, long_q, long_d;

  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (press_s[0]) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (in_hold_s[0]) begin
      if (hold_q == HOLD_LAST) begin
        if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else begin
      hold_d  = '0;
      fired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign botonSleep = pulse_s[0];
  assign botonAwake = pulse_s[1];
  assign botonFeed  = pulse_s[2];
  assign botonPlay  = pulse_s[3];
  assign giro       = lvl_s[4];
  assign long_sleep = long_q;

endmodule

// File: tb/tb_boton_acondicionador.sv
// Bench for boton_acondicionador: directed scenarios plus random button activity, each cycle
// compared against a run-length reference model of the debounce and long-press rules.
module tb_boton_acondicionador;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] raw = 5'b11111;  // {giro, play, feed, awake, sleep}, active low
  logic botonSleep, botonAwake, botonFeed, botonPlay, giro, long_sleep;

  boton_acondicionador #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .btn_sleep_r(raw[0]), .btn_awake_r(raw[1]), .btn_feed_r(raw[2]),
    .btn_play_r(raw[3]), .giro_r(raw[4]),
    .botonSleep(botonSleep), .botonAwake(botonAwake), .botonFeed(botonFeed),
    .botonPlay(botonPlay), .giro(giro), .long_sleep(long_sleep)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [4:0] m_s1, m_s2;
  int  m_run[5];
  bit  m_lvl[5];
  bit  m_arm[5];
  int  m_rdy, m_hold;
  bit  m_fired;
  logic [3:0] e_pulse;
  logic e_giro, e_long;

  // per-scenario tallies of what the DUT did
  int step_no;
  int pcount[4];
  int pfirst[4];
  int lcount, lfirst, grise, gfall_first;
  logic giro_prev;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 5'b11111; m_s2 = 5'b11111;
    for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_lvl[i] = 1'b0; m_arm[i] = 1'b0; end
    m_rdy = 0; m_hold = 0; m_fired = 1'b0;
    e_pulse = 4'b0000; e_giro = 1'b0; e_long = 1'b0;
  endtask

  // a level flips after DEB+1 consecutive samples disagreeing with it
  task automatic model_edge(input logic [4:0] raw_now);
    logic [4:0] p;
    bit ready, old_sleep;
    p = ~m_s2;
    ready = (m_rdy >= 2);
    old_sleep = m_lvl[0];
    e_long = 1'b0;
    if (m_lvl[0] && m_hold == LONG - 1 && !m_fired) begin
      e_long = 1'b1;
      m_fired = 1'b1;
    end
    e_pulse = 4'b0000;
    for (int ch = 0; ch < 5; ch++) begin
      bit old_lvl;
      old_lvl = m_lvl[ch];
      if (p[ch] != old_lvl && (old_lvl || m_arm[ch])) m_run[ch]++;
      else m_run[ch] = 0;
      if (m_run[ch] == DEB + 1) begin
        m_lvl[ch] = !old_lvl;
        m_run[ch] = 0;
        if (ch < 4) e_pulse[ch] = m_lvl[ch];
      end
      if (ready && !p[ch]) m_arm[ch] = 1'b1;
    end
    if (m_lvl[0] && !old_sleep) begin
      m_hold = 0; m_fired = 1'b0;
    end else if (old_sleep) begin
      if (m_hold < LONG - 1) m_hold++;
    end else begin
      m_hold = 0; m_fired = 1'b0;
    end
    e_giro = m_lvl[4];
    m_s2 = m_s1;
    m_s1 = raw_now;
    if (m_rdy < 10) m_rdy++;
  endtask

  task automatic clear_tally();
    step_no = 0;
    for (int i = 0; i < 4; i++) begin pcount[i] = 0; pfirst[i] = 0; end
    lcount = 0; lfirst = 0; grise = 0; gfall_first = 0;
    giro_prev = giro;
  endtask

  task automatic step(input logic [4:0] mask);
    logic [3:0] obs;
    raw = ~mask;
    @(posedge clk);
    model_edge(raw);
    #1;
    obs = {botonPlay, botonFeed, botonAwake, botonSleep};
    chk("pulses", int'(obs), int'(e_pulse));
    chk("giro", int'(giro), int'(e_giro));
    chk("long_sleep", int'(long_sleep), int'(e_long));
    step_no++;
    for (int i = 0; i < 4; i++) if (obs[i]) begin
      pcount[i]++;
      if (pfirst[i] == 0) pfirst[i] = step_no;
    end
    if (long_sleep) begin lcount++; if (lfirst == 0) lfirst = step_no; end
    if (giro && !giro_prev) grise++;
    if (!giro && giro_prev && gfall_first == 0) gfall_first = step_no;
    giro_prev = giro;
  endtask

  task automatic hold(input logic [4:0] mask, input int n);
    for (int i = 0; i < n; i++) step(mask);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    chk("outputs_in_reset", int'({botonSleep, botonAwake, botonFeed, botonPlay, giro, long_sleep}), 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("outputs_in_reset", int'({botonSleep, botonAwake, botonFeed, botonPlay, giro, long_sleep}), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] rmask;
    #2;
    do_reset(3);
    hold(5'b00000, 8);

    // 1: single feed press
    clear_tally();
    hold(5'b00100, 30);
    chk("feed_count", pcount[2], 1);
    chk("feed_latency", pfirst[2], 2 + DEB + 1);
    chk("others_quiet", pcount[0] + pcount[1] + pcount[3] + lcount, 0);
    hold(5'b00000, 10);

    // 2: play glitch then clean press
    clear_tally();
    hold(5'b01000, 3);
    hold(5'b00000, 10);
    chk("play_glitch", pcount[3], 0);
    hold(5'b01000, 10);
    hold(5'b00000, 10);
    chk("play_clean", pcount[3], 1);

    // 3: long sleep hold, twice
    for (int r = 0; r < 2; r++) begin
      clear_tally();
      hold(5'b00001, 40);
      chk("sleep_count", pcount[0], 1);
      chk("long_count", lcount, 1);
      chk("long_delay", lfirst - pfirst[0], LONG);
      hold(5'b00000, 10);
    end

    // 4: bouncing tilt
    clear_tally();
    step(5'b10000); step(5'b00000); step(5'b10000);
    hold(5'b10000, 20);
    chk("giro_rise_once", grise, 1);
    chk("giro_level", int'(giro), 1);
    clear_tally();
    hold(5'b00000, 12);
    chk("giro_fall_delay", gfall_first, 2 + DEB + 1);

    // 5: simultaneous sleep + play
    clear_tally();
    hold(5'b01001, 10);
    chk("simul_sleep", pcount[0], 1);
    chk("simul_play", pcount[3], 1);
    chk("simul_same_cycle", pfirst[0], pfirst[3]);
    hold(5'b00000, 10);

    // 6: reset while awake is being debounced
    clear_tally();
    hold(5'b00010, 5);
    do_reset(2);
    clear_tally();
    hold(5'b00010, 20);
    chk("awake_after_reset", pcount[1], 0);
    hold(5'b00000, 10);
    hold(5'b00010, 10);
    chk("awake_repress", pcount[1], 1);
    hold(5'b00000, 10);

    // random activity, buttons toggling with bursts of bounce
    rmask = 5'b00000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 5) == 0) rmask[b] = ~rmask[b];
      if ($urandom_range(0, 40) == 0) rmask[0] = 1'b1;
      step(rmask);
    end
    hold(5'b00001, 35);
    hold(5'b00000, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
